// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: registered round-robin grant with done release and hold timeout
module ffo #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_out
);
  assign o_out = i_in & (-i_in);
endmodule

module rr_grant_sequencer #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t               r_state, w_state;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [IDX_W-1:0]     r_idx, w_idx, r_last, w_last, w_cand_idx;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic                 r_timeout, w_timeout;
  logic [NUM_REQ-1:0]   w_mask, w_req_eff, w_ffo_m, w_ffo_u, w_cand;

  function automatic logic [IDX_W-1:0] enc(input logic [NUM_REQ-1:0] v);
    enc = '0;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) enc = enc | IDX_W'(i);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
    assign w_mask[i] = i > int'(r_last);
  end

  // the owner is excluded from the back-to-back re-pick on release
  assign w_req_eff = (r_state == GRANT) ? req & ~r_gnt : req;

  ffo #(.W(NUM_REQ)) u_ffo_m (.i_in(w_req_eff & w_mask), .o_out(w_ffo_m));
  ffo #(.W(NUM_REQ)) u_ffo_u (.i_in(w_req_eff), .o_out(w_ffo_u));

  assign w_cand     = |w_ffo_m ? w_ffo_m : w_ffo_u;
  assign w_cand_idx = enc(w_cand);

  // next-state: grant from idle, release or re-pick on done, revoke on hold limit
  always_comb begin
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_idx     = r_idx;
    w_last    = r_last;
    w_cnt     = r_cnt;
    w_timeout = 1'b0;
    if (r_state == IDLE || done) begin
      w_state = |w_req_eff ? GRANT : IDLE;
      w_gnt   = w_cand;
      w_idx   = w_cand_idx;
      w_last  = |w_req_eff ? w_cand_idx : r_last;
      w_cnt   = '0;
    end else if (r_cnt == CNT_W'(MAX_HOLD - 1)) begin
      w_state   = IDLE;
      w_gnt     = '0;
      w_idx     = '0;
      w_cnt     = '0;
      w_timeout = 1'b1;
    end else begin
      w_cnt = r_cnt + CNT_W'(1);
    end
  end

  // state and grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_gnt     <= w_gnt;
      r_idx     <= w_idx;
      r_last    <= w_last;
      r_cnt     <= w_cnt;
      r_timeout <= w_timeout;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_idx   = r_idx;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed scoreboard bench for the round-robin grant sequencer
module tb_rr_grant_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;
  logic [4:0] q[$];
  int         checks = 0;
  int         passes = 0;

  rr_grant_sequencer #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // apply inputs for one edge and queue the output expected after it
  task automatic step(input logic rs, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic et);
    rst = rs;
    req = r;
    done = d;
    @(posedge clk);
    #1;
    q.push_back({eg, et});
  endtask

  // monitor: pop one expectation per cycle and compare all outputs
  initial begin
    logic [4:0] e;
    logic [1:0] ei;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        ei = 2'd0;
        for (int i = 0; i < 4; i++) if (e[i+1]) ei = 2'(i);
        checks++;
        if (gnt === e[4:1] && gnt_valid === |e[4:1] && gnt_idx === ei && timeout === e[0])
          passes++;
        else
          $display("FAIL out t=%0t: gnt=%b valid=%b idx=%0d timeout=%b, required gnt=%b valid=%b idx=%0d timeout=%b",
                   $time, gnt, gnt_valid, gnt_idx, timeout, e[4:1], |e[4:1], ei, e[0]);
      end
    end
  end

  initial begin
    step(1, 4'b0000, 0, 4'b0000, 0);
    step(1, 4'b0000, 0, 4'b0000, 0);
    repeat (5) step(0, 4'b0000, 0, 4'b0000, 0);
    // idx1 then back-to-back to idx3, then release to idle
    step(0, 4'b1010, 0, 4'b0010, 0);
    step(0, 4'b1010, 1, 4'b1000, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);
    // fairness rotation 0,1,2,3,0 with done every third cycle
    step(0, 4'b1111, 0, 4'b0001, 0);
    step(0, 4'b1111, 0, 4'b0001, 0);
    step(0, 4'b1111, 0, 4'b0001, 0);
    step(0, 4'b1111, 1, 4'b0010, 0);
    step(0, 4'b1111, 0, 4'b0010, 0);
    step(0, 4'b1111, 0, 4'b0010, 0);
    step(0, 4'b1111, 1, 4'b0100, 0);
    step(0, 4'b1111, 0, 4'b0100, 0);
    step(0, 4'b1111, 0, 4'b0100, 0);
    step(0, 4'b1111, 1, 4'b1000, 0);
    step(0, 4'b1111, 0, 4'b1000, 0);
    step(0, 4'b1111, 0, 4'b1000, 0);
    step(0, 4'b1111, 1, 4'b0001, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);
    // timeout: 16 grant cycles, one timeout cycle, then re-grant
    step(0, 4'b0100, 0, 4'b0100, 0);
    repeat (15) step(0, 4'b0100, 0, 4'b0100, 0);
    step(0, 4'b0100, 0, 4'b0000, 1);
    step(0, 4'b0100, 0, 4'b0100, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);
    // done coincides with the hold limit: normal release, no timeout
    step(0, 4'b0100, 0, 4'b0100, 0);
    repeat (15) step(0, 4'b0100, 0, 4'b0100, 0);
    step(0, 4'b0100, 1, 4'b0000, 0);
    step(0, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0000, 0, 4'b0000, 0);
    // reset mid-grant, then priority restarts at bit 0
    step(0, 4'b1000, 0, 4'b1000, 0);
    step(1, 4'b1000, 0, 4'b0000, 0);
    step(0, 4'b1001, 0, 4'b0001, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
- Registered round-robin grant stage built around the find-first-one picker.
- Holds requester masks and a rotating priority pointer, and presents masked and unmasked request vectors to two find-first-one instances.
- Consumes their one-hot outputs and issues a registered, locked grant that lasts until the owner signals done or a hold timeout fires.
- Sits between requesters and the shared resource; the picker stays purely combinational inside this block.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- IDX_W, $clog2(NUM_REQ), width of the encoded grant index.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced revoke; must be at least 2.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  NUM_REQ  registered one-hot grant, or all zero.
- gnt_valid  output  1  high iff gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted bit; 0 when gnt_valid=0.
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Reset (rst=1 at a clock edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - state=IDLE, hold counter=0, last_idx=NUM_REQ-1, so bit 0 has first priority.
  - Reset asserted mid-grant drops the grant at that edge with no timeout pulse.
- Pick function:
  - mask[i] = (i > last_idx).
  - Candidate = FFO(req & mask) if that vector is non-zero, else FFO(req).
  - Result is one-hot or zero; index encoded combinationally for registering.
- IDLE state:
  - If |req, then at the next edge gnt=candidate, gnt_idx=its index, gnt_valid=1, last_idx=index, counter=0, state goes to GRANT.
  - Latency is one cycle from req to gnt.
  - done is ignored in IDLE.
- GRANT state:
  - gnt is held stable regardless of req changes; the lock stays even if the owner drops req.
  - Counter increments each cycle.
  - done=1: release the grant. If any req bit other than the owner's is set, pick using the updated last_idx and grant back-to-back at the same edge, with gnt changing directly from old to new one-hot. Otherwise go to IDLE with gnt=0. The owner's own req is excluded from this immediate re-pick; it may re-win from IDLE the following cycle.
  - Counter reaches MAX_HOLD-1 with done=0: force revoke. timeout=1 for one cycle, gnt=0, state goes to IDLE, last_idx keeps the revoked index so that requester becomes lowest priority.
  - done and the timeout condition in the same cycle: done wins and timeout stays 0.
- Wrap-around: when last_idx=NUM_REQ-1 the mask is all zero, so selection falls back to the lowest set bit.
- Invariants:
  - gnt is never multi-hot.
  - gnt_valid equals |gnt.
  - timeout never coincides with gnt_valid.
- Width rules: gnt_idx is zero-extended to IDX_W; the counter saturates by construction and never wraps.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- req=4'b1010 from IDLE -> next cycle gnt=4'b0010, gnt_idx=1. done pulse with req still 4'b1010 -> next cycle gnt=4'b1000, gnt_idx=3, no idle gap.
- Fairness: req=4'b1111 held, done asserted every 3rd cycle -> grants rotate through idx 0,1,2,3,0 in order.
- Timeout: MAX_HOLD=16, req=4'b0100, done held low -> gnt=4'b0100 for exactly 16 cycles, then timeout=1 for one cycle with gnt=0, then re-grant to idx 2 one cycle later (req still 4'b0100).
- Simultaneous: done=1 on the same cycle the counter hits MAX_HOLD-1 -> timeout stays 0 and a normal release occurs.
- Reset mid-grant with gnt=4'b1000 -> next cycle gnt=0 and timeout=0. With req=4'b1001 afterwards -> grant goes to idx 0, confirming last_idx was reset.
